seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It replaces the static all-on segment/display tie-offs in the counter top level. Counter (or any) logic loads a packed nibble value, and the block scans the digits with a ghost-suppression blanking gap. It supports hex or decimal rendering, per-digit dots and frame-synchronous value updates.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 25000, clock cycles per digit slot (≥ 4)
- BLANK_CYCLES, 64, cycles at start of each slot with all digits off (1..REFRESH_DIV-2)

Ports:
- clk  in  1  system clock; only clock
- i_reset  in  1  synchronous, active-high reset
- i_value  in  4*NUM_DIGITS  digit k nibble = i_value[4k+3:4k]
- i_dot  in  NUM_DIGITS  dot request per digit, 1 = lit
- i_load  in  1  capture i_value/i_dot into pending registers this cycle
- i_mode  in  1  0 = hex, 1 = decimal (nibbles 10..15 render as "-")
- o_segment_enable  out  [0:6]  segments a..g, active-low (0 = lit)
- o_display_enable  out  [0:NUM_DIGITS-1]  digit select, active-low
- o_dot_enable  out  1  dot segment, active-low
- o_frame_start  out  1  one-cycle pulse at start of digit 0 slot

## Operation
- Registers: pending (value, dot), shown (value, dot), slot_cnt (0..REFRESH_DIV-1), digit_idx (0..NUM_DIGITS-1), outputs.
- slot_cnt increments every cycle and wraps at REFRESH_DIV-1. On wrap, digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
- Commit: on the cycle where slot_cnt wraps and digit_idx wraps to 0, shown <= pending (pre-update value).
- i_load: pending <= {i_value, i_dot} next edge. A load on the commit cycle is not committed until the following frame.
- Slot phases:
  - BLANK (slot_cnt < BLANK_CYCLES): all display, segment and dot enables = 1.
  - DRIVE: o_display_enable[digit_idx] = 0, others 1. Segments show the decoded nibble shown[digit_idx], and the dot shows shown.dot[digit_idx].
- Decode in hex mode: standard glyphs 0-9, A, b, C, d, E, F.
- Decode in decimal mode: 0-9 as hex; 10..15 drive g only (o_segment_enable = 7'b1111110).
- i_mode is sampled live; it is not committed.
- Reset: all outputs 1 (everything off), o_frame_start 0, slot_cnt 0, digit_idx 0, pending/shown 0.

## Timing
- Outputs are registered. They reflect the slot_cnt/digit_idx of the previous cycle.
- First cycle after i_reset deasserts: internal slot 0 of digit 0. o_frame_start = 1 in the following cycle. Outputs are in BLANK for BLANK_CYCLES cycles.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. o_frame_start period is exactly this.
- i_load to visible latency: at most one frame plus 1 cycle after commit. Visible once digit 0 leaves BLANK.
- Reset mid-frame: next edge returns to reset state. Pending loads are discarded.
- i_load held high: pending tracks i_value every cycle. The frame commits whichever value was captured last before the commit cycle.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking.
  - Every digit above the highest nonzero nibble of shown is treated as blank.
  - Digit 0 is never blanked.
  - In DRIVE phase, a blank digit keeps o_display_enable = 1, unless its dot bit is set. In that case it is enabled with segments all 1 and the dot lit.
- Undefined: all digits always rendered. Zero shows "0" in every position.

## Structure
- Package seg7_pkg holds:
  - the 16-entry active-low glyph constant array, indexed by nibble, bit order a..g
  - the DASH glyph constant
  - the phase enum {BLANK, DRIVE}
- Sub-module seg7_decode (combinational nibble + mode → 7 segments) is shared with other display users.
- Top logic is the scan counters, commit and output registers.

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset release → all outputs 1 for 3 cycles. o_frame_start pulses once every 32 cycles.
- Load 16'h12AF, mode 0 → per frame:
  - digit0 F (0111000)
  - digit1 A (0001000)
  - digit2 2 (0010010)
  - digit3 1 (1001111)
  - each digit lit for 6 cycles per slot, with 2-cycle all-off gaps
- Mode 1 with 16'h12AF → digits 0 and 1 show 1111110. Digits 2 and 3 are unchanged.
- i_load asserted mid-frame with 16'h0005, i_dot=4'b0010 → old value persists until the next o_frame_start, then 5 on digit0 with the dot on digit1.
- SEG7_LZ_BLANK_EN, value 16'h0000, dot 4'b0100:
  - digit0 shows "0"
  - digits 1 and 3 are never enabled
  - digit2 is enabled with segments 1111111 and o_dot_enable 0
- Assert i_reset during digit2's DRIVE phase → all outputs 1 next cycle. After release, shown = 0 and the scan restarts at digit0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment display users.
// Glyph table (active-low, bit order a..g), dash glyph and scan phase.
package seg7_pkg;

   typedef enum logic {BLANK, DRIVE} phase_t;

   localparam logic [0:6] DASH = 7'b1111110;

   localparam logic [0:6] GLYPH [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment pattern (a..g).
// Decimal mode renders 10..15 as a dash.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       mode,
   output logic [0:6] segment
);

   // table lookup with dash override for non-decimal nibbles
   always_comb begin
      segment = GLYPH[nibble];
      if (mode && (nibble > 4'd9))
         segment = DASH;
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment scan driver.
// Optional macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 25000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    i_reset,
   input  logic [4*NUM_DIGITS-1:0] i_value,
   input  logic [NUM_DIGITS-1:0]   i_dot,
   input  logic                    i_load,
   input  logic                    i_mode,
   output logic [0:6]              o_segment_enable,
   output logic [0:NUM_DIGITS-1]   o_display_enable,
   output logic                    o_dot_enable,
   output logic                    o_frame_start
);

   localparam int SW = $clog2(REFRESH_DIV);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VW = 4 * NUM_DIGITS;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

   logic [VW-1:0]         pend_value;
   logic [NUM_DIGITS-1:0] pend_dot;
   logic [VW-1:0]         shown_value;
   logic [NUM_DIGITS-1:0] shown_dot;
   logic [SW-1:0]         slot_cnt;
   logic [DW-1:0]         digit_idx;

   logic                  slot_wrap;
   logic                  frame_wrap;
   phase_t                phase;
   logic [3:0]            nibble;
   logic                  dot;
   logic [0:6]            glyph;
   logic                  lz_blank;

   logic [0:6]            seg_nxt;
   logic [0:NUM_DIGITS-1] disp_nxt;
   logic                  dot_nxt;

   assign slot_wrap  = (slot_cnt == SLOT_LAST);
   assign frame_wrap = slot_wrap && (digit_idx == DIGIT_LAST);
   assign phase      = (slot_cnt < BLANK_END) ? BLANK : DRIVE;

   // slot counter and digit index
   always_ff @(posedge clk) begin
      if (i_reset) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else begin
         slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
         if (slot_wrap)
            digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
      end
   end

   // pending capture and frame-synchronous commit to shown
   always_ff @(posedge clk) begin
      if (i_reset) begin
         pend_value  <= '0;
         pend_dot    <= '0;
         shown_value <= '0;
         shown_dot   <= '0;
      end else begin
         if (i_load) begin
            pend_value <= i_value;
            pend_dot   <= i_dot;
         end
         if (frame_wrap) begin
            shown_value <= pend_value;
            shown_dot   <= pend_dot;
         end
      end
   end

   // pick the nibble and dot of the digit being scanned
   always_comb begin
      nibble = '0;
      dot    = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_idx == DW'(k)) begin
            nibble = shown_value[4*k +: 4];
            dot    = shown_dot[k];
         end
      end
   end

`ifdef SEG7_LZ_BLANK_EN
   logic [DW-1:0] hi_idx;

   // digits above the highest nonzero nibble are blank; digit 0 never is
   always_comb begin
      hi_idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (shown_value[4*k +: 4] != 4'd0)
            hi_idx = DW'(k);
      end
      lz_blank = (digit_idx > hi_idx);
   end
`else
   assign lz_blank = 1'b0;
`endif

   seg7_decode u_decode (
      .nibble  (nibble),
      .mode    (i_mode),
      .segment (glyph)
   );

   // next output pattern from phase, digit and blanking
   always_comb begin
      seg_nxt  = '1;
      disp_nxt = '1;
      dot_nxt  = 1'b1;
      if (phase == DRIVE) begin
         if (!lz_blank) begin
            disp_nxt[digit_idx] = 1'b0;
            seg_nxt             = glyph;
            dot_nxt             = ~dot;
         end else if (dot) begin
            disp_nxt[digit_idx] = 1'b0;
            dot_nxt             = 1'b0;
         end
      end
   end

   // registered outputs
   always_ff @(posedge clk) begin
      if (i_reset) begin
         o_segment_enable <= '1;
         o_display_enable <= '1;
         o_dot_enable     <= 1'b1;
         o_frame_start    <= 1'b0;
      end else begin
         o_segment_enable <= seg_nxt;
         o_display_enable <= disp_nxt;
         o_dot_enable     <= dot_nxt;
         o_frame_start    <= (slot_cnt == '0) && (digit_idx == '0);
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots).
// Reference model predicts outputs from elapsed time since reset.
module tb_seg7_scan_driver;

   localparam int ND    = 4;
   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = ND * RD;

   logic          clk = 1'b0;
   logic          i_reset;
   logic [15:0]   i_value;
   logic [3:0]    i_dot;
   logic          i_load;
   logic          i_mode;
   logic [0:6]    o_segment_enable;
   logic [0:ND-1] o_display_enable;
   logic          o_dot_enable;
   logic          o_frame_start;

   int checks   = 0;
   int failures = 0;

   logic [6:0] tbl [16];

   int          tcur;
   logic [15:0] m_pend_v;
   logic [3:0]  m_pend_d;
   logic [15:0] m_shown_v;
   logic [3:0]  m_shown_d;
   logic [0:6]  exp_seg;
   logic [0:3]  exp_disp;
   logic        exp_dot;
   logic        exp_fs;

   seg7_scan_driver #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk              (clk),
      .i_reset          (i_reset),
      .i_value          (i_value),
      .i_dot            (i_dot),
      .i_load           (i_load),
      .i_mode           (i_mode),
      .o_segment_enable (o_segment_enable),
      .o_display_enable (o_display_enable),
      .o_dot_enable     (o_dot_enable),
      .o_frame_start    (o_frame_start)
   );

   always #5 clk = ~clk;

   // expected outputs for the cycle at internal time tcur
   task automatic predict();
      int slot, dig, hi, nib;
      bit blank, d;
      slot     = tcur % RD;
      dig      = (tcur / RD) % ND;
      exp_fs   = ((tcur % FRAME) == 0);
      exp_seg  = '1;
      exp_disp = '1;
      exp_dot  = 1'b1;
      nib      = (m_shown_v >> (4 * dig)) & 15;
      d        = m_shown_d[dig];
      hi       = 0;
      for (int k = 0; k < ND; k++)
         if (((m_shown_v >> (4 * k)) & 15) != 0) hi = k;
      blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
      blank = (dig > hi);
`endif
      if (slot >= BC) begin
         if (!blank) begin
            exp_disp[dig] = 1'b0;
            exp_seg = (i_mode && nib > 9) ? 7'b1111110 : tbl[nib];
            exp_dot = ~d;
         end else if (d) begin
            exp_disp[dig] = 1'b0;
            exp_dot = 1'b0;
         end
      end
   endtask

   // advance model and one clock, then settle
   task automatic tick();
      if (i_reset) begin
         m_pend_v = '0; m_pend_d = '0;
         m_shown_v = '0; m_shown_d = '0;
         tcur = 0;
         exp_seg = '1; exp_disp = '1; exp_dot = 1'b1; exp_fs = 1'b0;
      end else begin
         predict();
         if ((tcur % FRAME) == FRAME - 1) begin
            m_shown_v = m_pend_v;
            m_shown_d = m_pend_d;
         end
         if (i_load) begin
            m_pend_v = i_value;
            m_pend_d = i_dot;
         end
         tcur++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({o_segment_enable, o_display_enable, o_dot_enable, o_frame_start}
          !== {7'h7f, 4'hf, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got %b %b %b %b", o_segment_enable,
                  o_display_enable, o_dot_enable, o_frame_start);
      end
      i_reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({o_segment_enable, o_display_enable, o_dot_enable} !== 12'hfff) begin
            failures++;
            $display("FAIL post_reset_off i=%0d got %b %b %b want all 1", i,
                     o_segment_enable, o_display_enable, o_dot_enable);
         end
         tick();
      end
   endtask

   task automatic test_frame_period();
      int last, n;
      last = -1;
      n = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         if (o_frame_start) begin
            if (last >= 0) begin
               checks++;
               if (i - last != FRAME) begin
                  failures++;
                  $display("FAIL frame_period got %0d want %0d", i - last, FRAME);
               end
            end
            last = i;
            n++;
         end
      end
      checks++;
      if (n != 3) begin
         failures++;
         $display("FAIL frame_count got %0d want 3", n);
      end
   endtask

   task automatic test_hex();
      i_value = 16'h12AF; i_dot = 4'h0; i_mode = 1'b0; i_load = 1'b1;
      tick();
      i_load = 1'b0;
      for (int i = 0; i < 2 * FRAME + 5; i++) begin
         tick();
         checks++;
         if ({o_segment_enable, o_display_enable, o_dot_enable, o_frame_start}
             !== {exp_seg, exp_disp, exp_dot, exp_fs}) begin
            failures++;
            $display("FAIL hex t=%0d got %b %b %b %b want %b %b %b %b", tcur,
                     o_segment_enable, o_display_enable, o_dot_enable,
                     o_frame_start, exp_seg, exp_disp, exp_dot, exp_fs);
         end
      end
   endtask

   task automatic test_decimal();
      i_mode = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         checks++;
         if ({o_segment_enable, o_display_enable, o_dot_enable, o_frame_start}
             !== {exp_seg, exp_disp, exp_dot, exp_fs}) begin
            failures++;
            $display("FAIL decimal t=%0d got %b %b %b %b want %b %b %b %b", tcur,
                     o_segment_enable, o_display_enable, o_dot_enable,
                     o_frame_start, exp_seg, exp_disp, exp_dot, exp_fs);
         end
      end
      i_mode = 1'b0;
   endtask

   task automatic test_midframe_load();
      int guard;
      guard = 0;
      while ((tcur % FRAME) != 12 && guard < 2 * FRAME) begin
         tick();
         guard++;
      end
      i_value = 16'h0005; i_dot = 4'b0010; i_load = 1'b1;
      tick();
      i_load = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         checks++;
         if ({o_segment_enable, o_display_enable, o_dot_enable, o_frame_start}
             !== {exp_seg, exp_disp, exp_dot, exp_fs}) begin
            failures++;
            $display("FAIL midload t=%0d got %b %b %b %b want %b %b %b %b", tcur,
                     o_segment_enable, o_display_enable, o_dot_enable,
                     o_frame_start, exp_seg, exp_disp, exp_dot, exp_fs);
         end
      end
   endtask

   task automatic test_lz_zero();
      i_value = 16'h0000; i_dot = 4'b0100; i_load = 1'b1;
      tick();
      i_load = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         checks++;
         if ({o_segment_enable, o_display_enable, o_dot_enable, o_frame_start}
             !== {exp_seg, exp_disp, exp_dot, exp_fs}) begin
            failures++;
            $display("FAIL lz_zero t=%0d got %b %b %b %b want %b %b %b %b", tcur,
                     o_segment_enable, o_display_enable, o_dot_enable,
                     o_frame_start, exp_seg, exp_disp, exp_dot, exp_fs);
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      i_value = 16'h9876; i_dot = 4'b1001; i_load = 1'b1;
      tick();
      i_load = 1'b0;
      guard = 0;
      while (!((tcur % FRAME) == 2 * RD + BC + 2 && tcur > FRAME)
             && guard < 4 * FRAME) begin
         tick();
         guard++;
      end
      checks++;
      if (guard >= 4 * FRAME) begin
         failures++;
         $display("FAIL reset_mid_wait got timeout want digit2 drive");
      end
      i_reset = 1'b1;
      tick();
      checks++;
      if ({o_segment_enable, o_display_enable, o_dot_enable, o_frame_start}
          !== {7'h7f, 4'hf, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid got %b %b %b %b want all off", o_segment_enable,
                  o_display_enable, o_dot_enable, o_frame_start);
      end
      i_reset = 1'b0;
      for (int i = 0; i < FRAME + 4; i++) begin
         tick();
         checks++;
         if ({o_segment_enable, o_display_enable, o_dot_enable, o_frame_start}
             !== {exp_seg, exp_disp, exp_dot, exp_fs}) begin
            failures++;
            $display("FAIL reset_restart t=%0d got %b %b %b %b want %b %b %b %b",
                     tcur, o_segment_enable, o_display_enable, o_dot_enable,
                     o_frame_start, exp_seg, exp_disp, exp_dot, exp_fs);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         i_value = 16'($urandom);
         i_dot   = 4'($urandom);
         i_load  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) i_mode = ~i_mode;
         if ($urandom_range(0, 3) == 0) i_value = i_value & 16'h00ff;
         i_reset = ($urandom_range(0, 299) == 0);
         tick();
         checks++;
         if ({o_segment_enable, o_display_enable, o_dot_enable, o_frame_start}
             !== {exp_seg, exp_disp, exp_dot, exp_fs}) begin
            failures++;
            $display("FAIL random t=%0d got %b %b %b %b want %b %b %b %b", tcur,
                     o_segment_enable, o_display_enable, o_dot_enable,
                     o_frame_start, exp_seg, exp_disp, exp_dot, exp_fs);
         end
      end
      i_reset = 1'b0;
      i_load  = 1'b0;
   endtask

   initial begin
      tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      i_reset = 1'b1;
      i_value = '0;
      i_dot   = '0;
      i_load  = 1'b0;
      i_mode  = 1'b0;
      tcur    = 0;
      test_reset();
      test_frame_period();
      test_hex();
      test_decimal();
      test_midframe_load();
      test_lz_zero();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
